// File: rtl/pixel_fetch_scheduler_if.sv
// rtl/pixel_fetch_scheduler_if.sv - CPU register bus and pixel pipeline signals of the fetch scheduler
interface pixel_fetch_scheduler_if;
    logic        capture_done;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        step;
    logic        frame_restart;
    logic [23:0] pix_rgb;

    modport slave (
        input  capture_done, avs_address, avs_read, avs_write, avs_writedata, pix_rgb,
        output avs_readdata, step, frame_restart
    );

    modport master (
        output capture_done, avs_address, avs_read, avs_write, avs_writedata, pix_rgb,
        input  avs_readdata, step, frame_restart
    );
endinterface

// File: rtl/pixel_fetch_scheduler.sv
// rtl/pixel_fetch_scheduler.sv - steps the raster readout pipeline to a CPU-requested pixel and latches its RGB value
module pixel_fetch_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PIPE_LAT = 2,
    parameter int STEP_GAP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    pixel_fetch_scheduler_if.slave bus
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [2:0]    A_STATUS   = 3'd0;
    localparam logic [2:0]    A_REQ      = 3'd1;
    localparam logic [2:0]    A_CTRL     = 3'd2;

    typedef enum logic [2:0] {S_NOFRAME, S_READY, S_STEP, S_GAP, S_DRAIN} state_t;

    state_t        r_state, w_state;
    logic [XW-1:0] r_x, w_x, r_tx, w_tx, w_step_x;
    logic [YW-1:0] r_y, w_y, r_ty, w_ty, w_step_y;
    logic          r_fresh, w_fresh;
    logic [GW-1:0] r_gap_cnt, w_gap_cnt;
    logic [DW-1:0] r_drain_cnt, w_drain_cnt;
    logic [23:0]   r_pixel, w_pixel;
    logic          r_valid, w_valid, r_err, w_err;
    logic [31:0]   r_readdata, w_readdata, w_status;
    logic [9:0]    w_req_x, w_req_y;
    logic          w_req_wr, w_ctl_wr, w_abort, w_in_range, w_busy, w_wrap, w_hit;

    assign w_req_x    = bus.avs_writedata[19:10];
    assign w_req_y    = bus.avs_writedata[9:0];
    assign w_req_wr   = bus.avs_write && (bus.avs_address == A_REQ);
    assign w_ctl_wr   = bus.avs_write && (bus.avs_address == A_CTRL);
    assign w_abort    = w_ctl_wr && bus.avs_writedata[1];
    assign w_in_range = ({22'd0, w_req_x} < 32'(H_ACTIVE)) && ({22'd0, w_req_y} < 32'(V_ACTIVE));
    assign w_busy     = (r_state == S_STEP) || (r_state == S_GAP) || (r_state == S_DRAIN);

    // r_fresh marks "nothing stepped yet this frame": pos reads (0,0) but the next step lands on (0,0) as a wrap
    assign w_wrap   = r_fresh || ((r_x == X_LAST) && (r_y == Y_LAST));
    assign w_step_x = (w_wrap || (r_x == X_LAST)) ? '0 : r_x + XW'(1);
    assign w_step_y = w_wrap ? '0 : ((r_x == X_LAST) ? r_y + YW'(1) : r_y);
    assign w_hit    = (w_step_x == r_tx) && (w_step_y == r_ty);

    assign w_status = {2'b00, 10'(r_x), 10'(r_y), 6'd0, r_err, r_valid, w_busy, (r_state != S_NOFRAME)};

    assign bus.avs_readdata  = r_readdata;
    assign bus.step          = (r_state == S_STEP);
    assign bus.frame_restart = (r_state == S_STEP) && w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_NOFRAME;
            r_x         <= '0;
            r_y         <= '0;
            r_fresh     <= 1'b1;
            r_tx        <= '0;
            r_ty        <= '0;
            r_gap_cnt   <= '0;
            r_drain_cnt <= '0;
            r_pixel     <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_readdata  <= '0;
        end else begin
            r_state     <= w_state;
            r_x         <= w_x;
            r_y         <= w_y;
            r_fresh     <= w_fresh;
            r_tx        <= w_tx;
            r_ty        <= w_ty;
            r_gap_cnt   <= w_gap_cnt;
            r_drain_cnt <= w_drain_cnt;
            r_pixel     <= w_pixel;
            r_valid     <= w_valid;
            r_err       <= w_err;
            r_readdata  <= w_readdata;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_x         = r_x;
        w_y         = r_y;
        w_fresh     = r_fresh;
        w_tx        = r_tx;
        w_ty        = r_ty;
        w_gap_cnt   = r_gap_cnt;
        w_drain_cnt = r_drain_cnt;
        w_pixel     = r_pixel;
        w_valid     = r_valid;
        w_err       = r_err;
        w_readdata  = r_readdata;

        // Read data is taken from current registers, so a same-cycle write is not yet visible
        if (bus.avs_read) begin
            case (bus.avs_address)
                A_STATUS: w_readdata = w_status;
                A_REQ:    w_readdata = {8'h00, r_pixel};
                default:  w_readdata = 32'd0;
            endcase
        end

        if (w_ctl_wr && bus.avs_writedata[0]) begin
            w_err = 1'b0;
        end

        if (!bus.capture_done) begin
            w_state = S_NOFRAME;
            w_valid = 1'b0;
            w_x     = '0;
            w_y     = '0;
            w_fresh = 1'b1;
            if (w_req_wr) begin
                w_err = 1'b1;
            end
        end else begin
            case (r_state)
                S_NOFRAME: begin
                    w_state = S_READY;
                    if (w_req_wr) begin
                        w_err = 1'b1;
                    end
                end
                S_READY: begin
                    if (w_req_wr) begin
                        if (w_in_range) begin
                            w_state = S_STEP;
                            w_tx    = w_req_x[XW-1:0];
                            w_ty    = w_req_y[YW-1:0];
                            w_valid = 1'b0;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    w_x     = w_step_x;
                    w_y     = w_step_y;
                    w_fresh = 1'b0;
                    if (w_hit) begin
                        w_state     = S_DRAIN;
                        w_drain_cnt = '0;
                    end else if (STEP_GAP == 0) begin
                        w_state = S_STEP;
                    end else begin
                        w_state   = S_GAP;
                        w_gap_cnt = '0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_state = S_STEP;
                    end else begin
                        w_gap_cnt = r_gap_cnt + GW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        w_pixel = bus.pix_rgb;
                        w_valid = 1'b1;
                        w_state = S_READY;
                    end else begin
                        w_drain_cnt = r_drain_cnt + DW'(1);
                    end
                end
                default: w_state = S_NOFRAME;
            endcase

            // An abort keeps any position advance already pulsed out but drops a pending pixel latch
            if (w_busy) begin
                if (w_req_wr) begin
                    w_err = 1'b1;
                end
                if (w_abort) begin
                    w_state = S_READY;
                    w_valid = 1'b0;
                    w_pixel = r_pixel;
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_fetch_scheduler.sv
// tb/tb_pixel_fetch_scheduler.sv - directed self-checking bench for pixel_fetch_scheduler
`timescale 1ns/1ps
module tb_pixel_fetch_scheduler;
    localparam int H = 16;
    localparam int V = 8;
    localparam logic [2:0] A_STATUS = 3'd0, A_REQ = 3'd1, A_CTRL = 3'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pixel_fetch_scheduler_if ia();
    pixel_fetch_scheduler_if ib();

    pixel_fetch_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .PIPE_LAT(2), .STEP_GAP(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );
    pixel_fetch_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .PIPE_LAT(3), .STEP_GAP(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave)
    );

    function automatic logic [23:0] pix(input int x, input int y);
        return {4'hC, 10'(x), 10'(y)};
    endfunction

    // Pipeline models: own raster position, PIPE_LAT-deep delay line, filler value when not stepped
    int          ma_x = H - 1, ma_y = V - 1, ma_steps = 0, ma_rst = 0;
    logic [23:0] ma_p0 = 24'hEEEEEE, ma_p1 = 24'hEEEEEE;
    assign ia.pix_rgb = ma_p1;
    always @(posedge clk) begin
        ma_p1 <= ma_p0;
        ma_p0 <= 24'hEEEEEE;
        if (ia.step) begin
            ma_steps <= ma_steps + 1;
            if (ia.frame_restart || (ma_x == H - 1 && ma_y == V - 1)) begin
                ma_x <= 0; ma_y <= 0; ma_p0 <= pix(0, 0);
            end else if (ma_x == H - 1) begin
                ma_x <= 0; ma_y <= ma_y + 1; ma_p0 <= pix(0, ma_y + 1);
            end else begin
                ma_x <= ma_x + 1; ma_p0 <= pix(ma_x + 1, ma_y);
            end
            if (ia.frame_restart) ma_rst <= ma_rst + 1;
        end
    end

    int          mb_x = H - 1, mb_y = V - 1, mb_steps = 0, mb_rst = 0, mb_run = 0;
    logic        mb_prev = 1'b0;
    logic [23:0] mb_p0 = 24'hEEEEEE, mb_p1 = 24'hEEEEEE, mb_p2 = 24'hEEEEEE;
    assign ib.pix_rgb = mb_p2;
    always @(posedge clk) begin
        mb_p2   <= mb_p1;
        mb_p1   <= mb_p0;
        mb_p0   <= 24'hEEEEEE;
        mb_prev <= ib.step;
        if (ib.step) begin
            mb_steps <= mb_steps + 1;
            mb_run   <= mb_prev ? mb_run + 1 : 1;
            if (ib.frame_restart || (mb_x == H - 1 && mb_y == V - 1)) begin
                mb_x <= 0; mb_y <= 0; mb_p0 <= pix(0, 0);
            end else if (mb_x == H - 1) begin
                mb_x <= 0; mb_y <= mb_y + 1; mb_p0 <= pix(0, mb_y + 1);
            end else begin
                mb_x <= mb_x + 1; mb_p0 <= pix(mb_x + 1, mb_y);
            end
            if (ib.frame_restart) mb_rst <= mb_rst + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input int sel, input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        if (sel == 0) begin ia.avs_address = addr; ia.avs_writedata = data; ia.avs_write = 1'b1; end
        else          begin ib.avs_address = addr; ib.avs_writedata = data; ib.avs_write = 1'b1; end
        @(negedge clk);
        ia.avs_write = 1'b0;
        ib.avs_write = 1'b0;
    endtask

    task automatic bus_rd(input int sel, input logic [2:0] addr, input logic wr,
                          input logic [31:0] wdata, output logic [31:0] data);
        @(negedge clk);
        if (sel == 0) begin ia.avs_address = addr; ia.avs_read = 1'b1; ia.avs_write = wr; ia.avs_writedata = wdata; end
        else          begin ib.avs_address = addr; ib.avs_read = 1'b1; ib.avs_write = wr; ib.avs_writedata = wdata; end
        @(negedge clk);
        ia.avs_read = 1'b0; ia.avs_write = 1'b0;
        ib.avs_read = 1'b0; ib.avs_write = 1'b0;
        data = (sel == 0) ? ia.avs_readdata : ib.avs_readdata;
    endtask

    task automatic wait_idle(input int sel, input string tag, output logic [31:0] st);
        int n = 0;
        do begin
            bus_rd(sel, A_STATUS, 1'b0, 32'd0, st);
            n++;
        end while (st[1] && n < 1000);
        check({tag, "_done"}, {31'd0, st[1]}, 32'd0);
    endtask

    function automatic logic [31:0] req(input int x, input int y);
        return {12'd0, 10'(x), 10'(y)};
    endfunction

    function automatic logic [31:0] stat(input int x, input int y, input logic [3:0] flags);
        return {2'b00, 10'(x), 10'(y), 6'd0, flags};
    endfunction

    logic [31:0] st, rd;
    int          s0, r0;

    initial begin
        ia.capture_done = 1'b0; ia.avs_address = '0; ia.avs_read = 1'b0; ia.avs_write = 1'b0; ia.avs_writedata = '0;
        ib.capture_done = 1'b1; ib.avs_address = '0; ib.avs_read = 1'b0; ib.avs_write = 1'b0; ib.avs_writedata = '0;
        repeat (3) @(negedge clk);
        check("rst_step", {31'd0, ia.step}, 32'd0);
        check("rst_restart", {31'd0, ia.frame_restart}, 32'd0);
        check("rst_readdata", ia.avs_readdata, 32'd0);
        rst = 1'b0;

        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("noframe_status", st, 32'd0);
        bus_wr(0, A_REQ, req(1, 0));
        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("noframe_req_err", st, 32'h8);
        bus_wr(0, A_CTRL, 32'h1);
        ia.capture_done = 1'b1;
        repeat (2) @(negedge clk);
        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("frame_ok", st, 32'h1);

        s0 = ma_steps; r0 = ma_rst;
        bus_wr(0, A_REQ, req(3, 0));
        wait_idle(0, "t1", st);
        check("t1_status", st, stat(3, 0, 4'b0101));
        check("t1_steps", ma_steps - s0, 4);
        check("t1_restarts", ma_rst - r0, 1);
        bus_rd(0, A_REQ, 1'b0, 32'd0, rd);
        check("t1_pixel", rd, {8'h00, pix(3, 0)});

        s0 = ma_steps; r0 = ma_rst;
        bus_wr(0, A_REQ, req(10, 5));
        wait_idle(0, "ahead", st);
        check("ahead_status", st, stat(10, 5, 4'b0101));
        check("ahead_steps", ma_steps - s0, 87);
        check("ahead_restarts", ma_rst - r0, 0);

        s0 = ma_steps; r0 = ma_rst;
        bus_wr(0, A_REQ, req(2, 5));
        wait_idle(0, "wrap", st);
        check("wrap_status", st, stat(2, 5, 4'b0101));
        check("wrap_steps", ma_steps - s0, H * V - 8);
        check("wrap_restarts", ma_rst - r0, 1);
        bus_rd(0, A_REQ, 1'b0, 32'd0, rd);
        check("wrap_pixel", rd, {8'h00, pix(2, 5)});

        s0 = ma_steps; r0 = ma_rst;
        bus_wr(0, A_REQ, req(2, 5));
        wait_idle(0, "same", st);
        check("same_steps", ma_steps - s0, H * V);
        check("same_restarts", ma_rst - r0, 1);

        s0 = ma_steps;
        bus_wr(0, A_REQ, req(H, 0));
        repeat (3) @(negedge clk);
        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("oor_x_err", st, stat(2, 5, 4'b1101));
        check("oor_x_nostep", ma_steps - s0, 0);
        bus_wr(0, A_CTRL, 32'h1);
        bus_wr(0, A_REQ, req(0, V));
        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("oor_y_err", st, stat(2, 5, 4'b1101));
        bus_wr(0, A_CTRL, 32'h1);
        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("err_clear", st, stat(2, 5, 4'b0101));

        s0 = ma_steps;
        bus_wr(0, A_REQ, req(5, 6));
        bus_wr(0, A_REQ, req(0, 0));
        wait_idle(0, "busyreq", st);
        check("busyreq_status", st, stat(5, 6, 4'b1101));
        check("busyreq_steps", ma_steps - s0, 19);
        bus_rd(0, A_REQ, 1'b0, 32'd0, rd);
        check("busyreq_pixel", rd, {8'h00, pix(5, 6)});
        bus_wr(0, A_CTRL, 32'h1);

        bus_rd(0, A_REQ, 1'b1, req(0, 0), rd);
        check("rdwr_pre_write", rd, {8'h00, pix(5, 6)});
        repeat (5) @(negedge clk);
        bus_wr(0, A_CTRL, 32'h2);
        s0 = ma_steps;
        repeat (8) @(negedge clk);
        check("abort_nostep", ma_steps - s0, 0);
        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("abort_status", st, stat(ma_x, ma_y, 4'b0001));
        bus_rd(0, A_REQ, 1'b0, 32'd0, rd);
        check("abort_stale_pixel", rd, {8'h00, pix(5, 6)});

        bus_wr(0, A_REQ, req(15, 7));
        repeat (4) @(negedge clk);
        ia.capture_done = 1'b0;
        @(negedge clk);
        s0 = ma_steps;
        repeat (6) @(negedge clk);
        check("drop_nostep", ma_steps - s0, 0);
        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("drop_status", st, 32'd0);
        ia.capture_done = 1'b1;
        repeat (2) @(negedge clk);
        s0 = ma_steps; r0 = ma_rst;
        bus_wr(0, A_REQ, req(1, 0));
        wait_idle(0, "newframe", st);
        check("newframe_status", st, stat(1, 0, 4'b0101));
        check("newframe_steps", ma_steps - s0, 2);
        check("newframe_restarts", ma_rst - r0, 1);
        bus_rd(0, A_REQ, 1'b0, 32'd0, rd);
        check("newframe_pixel", rd, {8'h00, pix(1, 0)});

        bus_wr(0, A_REQ, req(10, 3));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_step", {31'd0, ia.step}, 32'd0);
        check("arst_readdata", ia.avs_readdata, 32'd0);
        s0 = ma_steps;
        repeat (4) @(negedge clk);
        check("arst_nostep", ma_steps - s0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus_rd(0, A_STATUS, 1'b0, 32'd0, st);
        check("arst_status", st, 32'h1);

        s0 = mb_steps; r0 = mb_rst;
        bus_wr(1, A_REQ, req(0, 1));
        wait_idle(1, "b2b", st);
        check("b2b_status", st, stat(0, 1, 4'b0101));
        check("b2b_steps", mb_steps - s0, H + 1);
        check("b2b_run", mb_run, H + 1);
        check("b2b_restarts", mb_rst - r0, 1);
        bus_rd(1, A_REQ, 1'b0, 32'd0, rd);
        check("b2b_pixel", rd, {8'h00, pix(0, 1)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
